mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, data-bus address width.
REQ-002 SHALL have these ports: clock  in  1  clock.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 ex_valid  in  1  execute stage offers instruction.
REQ-005 ex_pc  in  32  instruction program count.
REQ-006 ex_alu_result  in  32  memory address or ALU result.
REQ-007 ex_dest  in  5  destination register; ex_reg_write  in  1  writes register.
REQ-008 ex_is_load, ex_is_store  in  1 each  memory operation kind; ex_load_unsigned  in  1  zero-extend load.
REQ-009 ex_mem_size  in  2  0=byte, 1=half, 2=word; ex_store_data  in  32  store value.
REQ-010 ms_allow_in  out  1  stage accepts; ws_allow_in  in  1  writeback accepts.
REQ-011 data_req, data_wr  out  1  bus request, write; data_size  out  2; data_addr  out  ADDR_W; data_wdata  out  32; data_wstrb  out  4.
REQ-012 data_addr_ok, data_data_ok  in  1  address accepted, data/response returned; data_rdata  in  32.
REQ-013 ms_to_ws_valid  out  1; ms_pc  out  32; ms_result  out  32; ms_dest  out  5; ms_reg_write  out  1.
REQ-014 bp_valid  out  1  pending write; bp_reg  out  5; bp_data_ready  out  1; bp_data  out  32  forwarding to decode.
REQ-015 ms_addr_error  out  1  misaligned access flag.

Function
REQ-016 SHALL hold one instruction in FSM states IDLE, REQ, WAIT, DONE.
REQ-017 ms_allow_in SHALL equal (state==IDLE) or (state==DONE and ws_allow_in).
REQ-018 On ex_valid and ms_allow_in, SHALL register all ex_* fields; next state REQ for load/store, DONE otherwise; without a new instruction, DONE with ws_allow_in SHALL go IDLE.
REQ-019 In REQ, data_req SHALL be 1 with address/size/wdata/wstrb stable until data_addr_ok; addr_ok moves to WAIT.
REQ-020 In WAIT, data_data_ok moves to DONE; loads capture the extended rdata into result; stores SHALL also wait for data_ok.
REQ-021 data_data_ok outside WAIT SHALL be ignored; slave never returns data_ok in the addr_ok cycle.
REQ-022 Minimum memory latency: accept cycle N, data_req at N+1, DONE at N+3 if addr_ok at N+1 and data_ok at N+2; non-memory op reaches DONE at N+1.
REQ-023 ms_to_ws_valid SHALL equal (state==DONE); outputs stay stable while ws_allow_in is 0.
REQ-024 Load extension: byte selects rdata lane addr[1:0], half selects lane addr[1]; sign-extend unless ex_load_unsigned; word passes through.
REQ-025 Store strobes: byte 4'b0001<<addr[1:0], half 4'b0011<<{addr[1],1'b0}, word 4'hf; wdata SHALL replicate the byte/half across lanes.
REQ-026 data_addr SHALL carry the full address; data_wr=ex_is_store; data_size=ex_mem_size.
REQ-027 bp_valid = (state!=IDLE and reg_write); bp_reg = dest; bp_data_ready = (state==DONE); bp_data = result.

Reset
REQ-028 Reset SHALL force IDLE and drive data_req, ms_to_ws_valid, bp_valid, bp_data_ready, ms_addr_error to 0; ms_allow_in SHALL be 1 in the first cycle after reset.
REQ-029 Reset mid-transaction SHALL abandon the access; bus slave is reset together.

Configuration
REQ-030 With ADDR_ERROR_EN defined: misaligned half (addr[0]) or word (addr[1:0]!=0) access SHALL skip REQ, enter DONE, set ms_addr_error=1, force ms_reg_write=0 and issue no data_req.
REQ-031 Without ADDR_ERROR_EN: ms_addr_error tied 0; misaligned accesses are issued as-is.

Verification
REQ-032 ALU op, ws_allow_in=1 -> ms_to_ws_valid one cycle after accept; bp_data_ready=1 same cycle.
REQ-033 lb at addr 0x1003, rdata 0x80xxxxxx -> result 0xFFFFFF80; lbu -> 0x00000080.
REQ-034 sh at 0x1002, data 0x1234 -> wstrb 4'b1100, wdata 0x12341234; addr_ok delayed 3 cycles -> data_req held stable.
REQ-035 DONE with ws_allow_in=0 for 4 cycles -> ms_allow_in=0, outputs unchanged; new op accepted the cycle ws_allow_in rises.
REQ-036 Reset in WAIT -> IDLE next cycle, later data_ok ignored; with ADDR_ERROR_EN, lw at 0x1002 -> no data_req, ms_addr_error=1.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: holds one instruction, drives the data bus, forwards to decode.
// Define ADDR_ERROR_EN to trap misaligned half/word accesses instead of issuing them.
module mem_access_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_alu_result,
  input  logic [4:0]        ex_dest,
  input  logic              ex_reg_write,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic              ex_load_unsigned,
  input  logic [1:0]        ex_mem_size,
  input  logic [31:0]       ex_store_data,
  output logic              ms_allow_in,
  input  logic              ws_allow_in,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              ms_to_ws_valid,
  output logic [31:0]       ms_pc,
  output logic [31:0]       ms_result,
  output logic [4:0]        ms_dest,
  output logic              ms_reg_write,
  output logic              bp_valid,
  output logic [4:0]        bp_reg,
  output logic              bp_data_ready,
  output logic [31:0]       bp_data,
  output logic              ms_addr_error
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;

  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic [31:0] r_result;
  logic [31:0] r_store_data;
  logic [4:0]  r_dest;
  logic [1:0]  r_mem_size;
  logic        r_reg_write;
  logic        r_is_load;
  logic        r_is_store;
  logic        r_load_unsigned;
  logic        r_addr_error;

  logic        w_accept;
  logic        w_ex_mem;
  logic        w_ex_misaligned;
  logic        w_load_done;
  logic [7:0]  w_rdata_byte;
  logic [15:0] w_rdata_half;
  logic [31:0] w_load_data;

  assign w_accept    = ex_valid && ms_allow_in;
  assign w_ex_mem    = ex_is_load || ex_is_store;
  assign w_load_done = (r_state == StWait) && data_data_ok && r_is_load;

`ifdef ADDR_ERROR_EN
  assign w_ex_misaligned = w_ex_mem &&
                           (((ex_mem_size == 2'd1) && ex_alu_result[0]) ||
                            ((ex_mem_size == 2'd2) && (ex_alu_result[1:0] != 2'b00)));
`else
  assign w_ex_misaligned = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  w_state_next = StIdle;
      StReq:   if (data_addr_ok) w_state_next = StWait;
      StWait:  if (data_data_ok) w_state_next = StDone;
      StDone:  if (ws_allow_in) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    // A new instruction overrides the hand-off from DONE
    if (w_accept) begin
      w_state_next = (w_ex_mem && !w_ex_misaligned) ? StReq : StDone;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_addr_error <= 1'b0;
    end else if (w_accept) begin
      r_reg_write  <= ex_reg_write && !w_ex_misaligned;
      r_addr_error <= w_ex_misaligned;
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_pc            <= ex_pc;
      r_addr          <= ex_alu_result;
      r_result        <= ex_alu_result;
      r_store_data    <= ex_store_data;
      r_dest          <= ex_dest;
      r_mem_size      <= ex_mem_size;
      r_is_load       <= ex_is_load;
      r_is_store      <= ex_is_store;
      r_load_unsigned <= ex_load_unsigned;
    end else if (w_load_done) begin
      r_result <= w_load_data;
    end
  end

  always_comb begin
    w_rdata_byte = data_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_rdata_half = r_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (r_mem_size)
      2'd0:    w_load_data = {{24{w_rdata_byte[7] & ~r_load_unsigned}}, w_rdata_byte};
      2'd1:    w_load_data = {{16{w_rdata_half[15] & ~r_load_unsigned}}, w_rdata_half};
      default: w_load_data = data_rdata;
    endcase
  end

  // Narrow stores replicate across all lanes; the strobe picks the live one
  always_comb begin
    case (r_mem_size)
      2'd0: begin
        data_wdata = {4{r_store_data[7:0]}};
        data_wstrb = 4'b0001 << r_addr[1:0];
      end
      2'd1: begin
        data_wdata = {2{r_store_data[15:0]}};
        data_wstrb = 4'b0011 << {r_addr[1], 1'b0};
      end
      default: begin
        data_wdata = r_store_data;
        data_wstrb = 4'hf;
      end
    endcase
  end

  assign ms_allow_in    = (r_state == StIdle) || ((r_state == StDone) && ws_allow_in);
  assign data_req       = (r_state == StReq);
  assign data_wr        = r_is_store;
  assign data_size      = r_mem_size;
  assign data_addr      = ADDR_W'(r_addr);
  assign ms_to_ws_valid = (r_state == StDone);
  assign ms_pc          = r_pc;
  assign ms_result      = r_result;
  assign ms_dest        = r_dest;
  assign ms_reg_write   = r_reg_write;
  assign bp_valid       = (r_state != StIdle) && r_reg_write;
  assign bp_reg         = r_dest;
  assign bp_data_ready  = (r_state == StDone);
  assign bp_data        = r_result;
  assign ms_addr_error  = r_addr_error && (r_state == StDone);

endmodule
